// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// sweep/run state encoding and the address-width helper.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH     = 64;
  localparam int unsigned DEF_DEPTH     = 32;
  localparam int unsigned DEF_NUM_READ  = 3;
  localparam int unsigned DEF_NUM_WRITE = 2;
  localparam int unsigned DEF_ZERO_REG  = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  // Address bits needed to index depth entries (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/maintenance bus of the register file; master = decode/writeback side.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned NUM_READ  = DEF_NUM_READ,
  parameter int unsigned NUM_WRITE = DEF_NUM_WRITE
);
  localparam int unsigned AW = addr_width(DEPTH);

  logic                       init_req;
  logic                       busy;
  logic [NUM_READ-1:0]        rd_en;
  logic [NUM_READ*AW-1:0]     rd_addr;
  logic [NUM_READ*WIDTH-1:0]  rd_data;
  logic [NUM_WRITE-1:0]       wr_en;
  logic [NUM_WRITE*AW-1:0]    wr_addr;
  logic [NUM_WRITE*WIDTH-1:0] wr_data;

  modport master (
    output init_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  busy, rd_data
  );

  modport slave (
    input  init_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output busy, rd_data
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: range/zero-register decode, write-first bypass
// (highest write port wins) and the output register that holds when disabled.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned NUM_WRITE = DEF_NUM_WRITE,
  parameter int unsigned ZERO_REG  = DEF_ZERO_REG,
  parameter int unsigned AW        = addr_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       blank_i,
  input  logic                       en_i,
  input  logic [AW-1:0]              addr_i,
  input  logic [WIDTH-1:0]           mem_i [DEPTH],
  input  logic [NUM_WRITE-1:0]       wr_en_i,
  input  logic [NUM_WRITE*AW-1:0]    wr_addr_i,
  input  logic [NUM_WRITE*WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0]           data_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             in_rng;
  logic             is_zero;

  if (DEPTH == (1 << AW)) begin : g_full
    assign in_rng = 1'b1;
  end else begin : g_part
    assign in_rng = ({1'b0, addr_i} < (AW+1)'(DEPTH));
  end

  assign is_zero = (ZERO_REG != 0) && (addr_i == AW'(DEPTH - 1));

  // Later write ports override earlier ones, so the loop order is the priority.
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      if (blank_i || !in_rng || is_zero) begin
        data_d = '0;
      end else begin
        data_d = mem_i[addr_i];
        for (int w = 0; w < int'(NUM_WRITE); w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == addr_i)) begin
            data_d = wr_data_i[w*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage array, write ports, clear-sweep FSM and
// NUM_READ registered read ports with write-first bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned NUM_READ  = DEF_NUM_READ,
  parameter int unsigned NUM_WRITE = DEF_NUM_WRITE,
  parameter int unsigned ZERO_REG  = DEF_ZERO_REG
) (
  input logic          clk,
  input logic          rst_n,
  regfile_mp_if.slave  bus
);

  localparam int unsigned AW = addr_width(DEPTH);

  rf_state_e        state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [NUM_WRITE-1:0] wr_ok;
  logic [WIDTH-1:0] rd_data_w [NUM_READ];
  logic [NUM_READ*WIDTH-1:0] rd_flat;

  // Per-port write qualification: in range and not the hard-wired zero entry.
  for (genvar w = 0; w < int'(NUM_WRITE); w++) begin : g_wr
    logic [AW-1:0] waddr;
    logic          in_rng;
    assign waddr = bus.wr_addr[w*AW +: AW];
    if (DEPTH == (1 << AW)) begin : g_full
      assign in_rng = 1'b1;
    end else begin : g_part
      assign in_rng = ({1'b0, waddr} < (AW+1)'(DEPTH));
    end
    assign wr_ok[w] = bus.wr_en[w] && in_rng &&
                      !((ZERO_REG != 0) && (waddr == AW'(DEPTH - 1)));
  end

  // Sweep FSM: INIT clears one entry per edge, then RUN until init_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + AW'(1);
          end
        end
        RUN: begin
          if (bus.init_req) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array is cleared by the sweep rather than by reset; port writes only in RUN.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_WRITE); w++) begin
        if (wr_ok[w]) begin
          mem_q[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_rd
    regfile_read_port #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .NUM_WRITE (NUM_WRITE),
      .ZERO_REG  (ZERO_REG),
      .AW        (AW)
    ) u_rd (
      .clk       (clk),
      .rst_n     (rst_n),
      .blank_i   (busy_q),
      .en_i      (bus.rd_en[p]),
      .addr_i    (bus.rd_addr[p*AW +: AW]),
      .mem_i     (mem_q),
      .wr_en_i   (bus.wr_en),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .data_o    (rd_data_w[p])
    );
  end

  always_comb begin
    rd_flat = '0;
    for (int p = 0; p < int'(NUM_READ); p++) begin
      rd_flat[p*WIDTH +: WIDTH] = rd_data_w[p];
    end
  end

  assign bus.rd_data = rd_flat;
  assign bus.busy    = busy_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the decode stage, successor to the single-write/dual-read file. Provides NUM_READ registered read ports and NUM_WRITE write ports on one clock, with write-first bypass, an optional hard-wired zero register (ARM XZR) and a hardware clear sweep after reset or on request. It feeds operand latches in decode and takes writeback from the execute/memory stages.

## Interface

- WIDTH, 64: register width in bits (`WORD`).
- DEPTH, 32: number of architectural registers; AW = $clog2(DEPTH).
- NUM_READ, 3: read ports (Rn, Rm, Rt for stores).
- NUM_WRITE, 2: write ports (result, load/base writeback).
- ZERO_REG, 1: when 1, index DEPTH-1 reads as 0 and ignores writes.
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- init_req  in  1  pulse in RUN starts a clear sweep.
- busy  out  1  high while sweeping; file unavailable.
- rd_en  in  NUM_READ  per-port read enable.
- rd_addr  in  NUM_READ*AW  port p at [p*AW +: AW].
- rd_data  out  NUM_READ*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH].
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*AW  port w at [w*AW +: AW].
- wr_data  in  NUM_WRITE*WIDTH  port w at [w*WIDTH +: WIDTH].

## Operation

- States: INIT, RUN. Reset forces INIT, sweep counter = 0, busy = 1, all rd_data = 0.
- INIT: each cycle writes 0 to entry[counter], counter++; when counter == DEPTH-1 that entry is cleared and state -> RUN. wr_en ignored (dropped, no side effect). Reads with rd_en return 0.
- RUN: init_req = 1 -> INIT, counter = 0 next cycle; writes in that same cycle still commit.
- Write: wr_en[w] with address != DEPTH-1 (or ZERO_REG = 0) and address < DEPTH writes wr_data[w] on posedge. Out-of-range addresses (DEPTH not power of two) are ignored.
- Same-address multi-write in one cycle: highest port index wins.
- Read: rd_en[p] = 1 -> rd_data[p] gets entry[rd_addr[p]] at posedge; rd_en[p] = 0 -> rd_data[p] holds. Out-of-range address reads 0.
- Bypass (write-first): if any enabled write in the same cycle targets rd_addr[p], rd_data[p] gets that write data (highest port wins), not the stale entry.
- Zero register: read of DEPTH-1 with ZERO_REG = 1 always returns 0, including under bypass.

## Timing

- Read latency 1 cycle: address at edge N-1..N, data valid after edge N.
- Write visible to a registered read issued in the same cycle (bypass); visible via array from the next cycle.
- busy asserts asynchronously on rst_n low; after rst_n rises, busy stays high for exactly DEPTH posedges and is low after the DEPTH-th edge.
- Writes accepted only on an edge where busy = 0 was sampled.
- rst_n low mid-sweep or mid-RUN: restart sweep from 0; array contents are not required to clear asynchronously (sweep does it).
- init_req while busy: ignored.

## Structure

- Shared package regfile_pkg: default WIDTH/DEPTH/port counts, state enum {INIT, RUN}, AW helper.
- One sub-module natural: regfile_read_port (address decode, bypass priority mux, zero-reg force, output register); instantiated NUM_READ times by generate. Array, write logic and sweep FSM stay in top.

## Test plan

- Reset release with DEPTH = 32: busy high 32 cycles, then low; read of X5 returns 0; write X5 = 0xDEAD issued during busy is dropped.
- RUN, write X3 = 0x1234 via port 0 and read X3 on port 1 same cycle -> rd_data[1] = 0x1234 one cycle later.
- Ports 0 and 1 both write X7 (0xAAAA, 0xBBBB) same cycle -> subsequent read X7 = 0xBBBB; simultaneous bypass read also 0xBBBB.
- Write X31 = 0xFFFF with ZERO_REG = 1 -> read X31 = 0, bypass read X31 = 0; with ZERO_REG = 0 -> 0xFFFF.
- rd_en low for port 2 after reading X3 = 0x1234, then X3 overwritten -> rd_data[2] holds 0x1234.
- init_req after filling X0..X30 with nonzero, rst_n pulsed low at sweep cycle 10 -> sweep restarts, busy high 32 cycles from release, all entries read 0.
